// File: rtl/mux_bus_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the eight-source bus arbiter.
// Latency: none (package only).
// Backpressure: not applicable.
package bus_arb_pkg;

    localparam int NUM_SRC = 8;
    localparam int SEL_W   = 3;

    // Last-owner pointer after reset; pointing at 7 gives source 0 first pick.
    localparam logic [SEL_W-1:0] PTR_RST = 3'd7;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_SRC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_bus_arbiter_if.sv
// Groups the request/grant, mux select and shared-bus signals of the arbiter.
// Latency: none (wiring only).
// Backpressure: none; a source keeps its grant only while it holds its request.
interface mux_bus_arbiter_if import bus_arb_pkg::*; #(
    parameter int DATA_W = 8
);
    logic [NUM_SRC-1:0] Req;
    logic [NUM_SRC-1:0] Grant;
    logic [SEL_W-1:0]   Sel;
    logic [SEL_W-1:0]   Owner;
    logic [DATA_W-1:0]  MuxY;
    logic [DATA_W-1:0]  BusData;
    logic               BusValid;

    // Arbiter side.
    modport master (
        input  Req,
        input  MuxY,
        output Grant,
        output Sel,
        output Owner,
        output BusData,
        output BusValid
    );

    // Sources plus the Mux8To1 side.
    modport slave (
        output Req,
        output MuxY,
        input  Grant,
        input  Sel,
        input  Owner,
        input  BusData,
        input  BusValid
    );

endinterface

// File: rtl/mux_bus_arbiter_picker.sv
// Round-robin picker: first set request at or after 'start', wrapping around.
// Latency: combinational.
// Backpressure: none; 'found' is low when no request is set.
module rr_picker8 import bus_arb_pkg::*; (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   start,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest candidate toward 'start' so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = start;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            cand = start + i[SEL_W-1:0];
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter for the 8:1 bus mux with bounded hold and registered bus sample.
// Latency: 1 cycle request-to-grant; bus sample lags grant by 1 cycle.
// Backpressure: owner keeps the bus while requesting, up to MAX_HOLD cycles.
module mux_bus_arbiter import bus_arb_pkg::*; #(
    parameter int MAX_HOLD = 4,
    parameter int DATA_W   = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    mux_bus_arbiter_if.master bus
);

    localparam int               HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);

    arb_state_t         state_q, state_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [SEL_W-1:0]   owner_q, owner_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;

    logic [SEL_W-1:0]   pick_start;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic               owner_req;
    logic               rel;

    // One picker serves both paths: from IDLE it starts after the last owner,
    // on release it starts after the current owner (which becomes the last owner).
    assign pick_start = ((state_q == IDLE) ? last_q : owner_q) + 3'd1;
    assign owner_req  = bus.Req[owner_q];
    assign rel        = !owner_req || (hold_q == HOLD_LAST);

    rr_picker8 u_picker (
        .req   (bus.Req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state and next-output decode; Sel/Owner are left alone when idle so the mux stays put.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        data_d  = data_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_found) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                    grant_d = onehot(pick_idx);
                    hold_d  = '0;
                end
            end
            GRANT: begin
                data_d  = bus.MuxY;
                valid_d = owner_req;
                if (rel) begin
                    last_d = owner_q;
                    hold_d = '0;
                    if (pick_found) begin
                        owner_d = pick_idx;
                        grant_d = onehot(pick_idx);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight sample.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            last_q  <= PTR_RST;
            owner_q <= '0;
            grant_q <= '0;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign bus.Grant    = grant_q;
    assign bus.Sel      = owner_q;
    assign bus.Owner    = owner_q;
    assign bus.BusData  = data_q;
    assign bus.BusValid = valid_q;

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Directed bench for mux_bus_arbiter with an ideal Mux8To1 whose inputs A..H are 0..7.
// Latency: n/a.
// Backpressure: n/a.
module tb_mux_bus_arbiter;
    import bus_arb_pkg::*;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   exp_o;

    mux_bus_arbiter_if #(.DATA_W(8)) bus ();

    // Mux8To1 with A..H tied to 0..7, so Y equals Sel.
    assign bus.MuxY = {5'd0, bus.Sel};

    mux_bus_arbiter #(.MAX_HOLD(4), .DATA_W(8)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.Req = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.Req  = 8'h00;

        // Reset state.
        do_reset();
        chk("rst_grant", 32'(bus.Grant), 32'h00);
        chk("rst_sel", 32'(bus.Sel), 32'd0);
        chk("rst_owner", 32'(bus.Owner), 32'd0);
        chk("rst_data", 32'(bus.BusData), 32'd0);
        chk("rst_valid", 32'(bus.BusValid), 32'd0);

        // 1: no requests keeps everything quiet.
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("idle_grant", 32'(bus.Grant), 32'h00);
            chk("idle_sel", 32'(bus.Sel), 32'd0);
            chk("idle_valid", 32'(bus.BusValid), 32'd0);
            chk("idle_data", 32'(bus.BusData), 32'd0);
        end

        // 2: single requester, hold expiry re-grants the same source.
        bus.Req = 8'h04;
        tick();
        chk("s2_grant", 32'(bus.Grant), 32'h04);
        chk("s2_sel", 32'(bus.Sel), 32'd2);
        chk("s2_valid0", 32'(bus.BusValid), 32'd0);
        tick();
        chk("s2_data", 32'(bus.BusData), 32'd2);
        chk("s2_valid", 32'(bus.BusValid), 32'd1);
        chk("s2_hold1", 32'(dut.hold_q), 32'd1);
        tick();
        tick();
        chk("s2_hold3", 32'(dut.hold_q), 32'd3);
        tick();
        chk("s2_regrant", 32'(bus.Grant), 32'h04);
        chk("s2_hold0", 32'(dut.hold_q), 32'd0);
        chk("s2_valid_regrant", 32'(bus.BusValid), 32'd1);
        bus.Req = 8'h00;
        tick();
        chk("s2_drop_grant", 32'(bus.Grant), 32'h00);
        chk("s2_drop_valid", 32'(bus.BusValid), 32'd0);
        chk("s2_drop_sel", 32'(bus.Sel), 32'd2);
        tick();
        chk("s2_idle_valid", 32'(bus.BusValid), 32'd0);
        chk("s2_idle_sel", 32'(bus.Sel), 32'd2);

        // 3: everyone requests, four cycles each, in order 0..7 then 0.
        do_reset();
        bus.Req = 8'hFF;
        for (int k = 0; k < 36; k++) begin
            tick();
            exp_o = (k / 4) % 8;
            chk("s3_grant", 32'(bus.Grant), 32'(1) << exp_o);
            chk("s3_sel", 32'(bus.Sel), 32'(exp_o));
            if (k > 0) begin
                chk("s3_data", 32'(bus.BusData), 32'(((k - 1) / 4) % 8));
                chk("s3_valid", 32'(bus.BusValid), 32'd1);
            end
        end

        // 4: owner drops its request, next requester taken with no gap.
        do_reset();
        bus.Req = 8'h81;
        tick();
        chk("s4_grant0", 32'(bus.Grant), 32'h01);
        tick();
        tick();
        chk("s4_data0", 32'(bus.BusData), 32'd0);
        chk("s4_valid0", 32'(bus.BusValid), 32'd1);
        bus.Req = 8'h80;
        tick();
        chk("s4_grant7", 32'(bus.Grant), 32'h80);
        chk("s4_sel7", 32'(bus.Sel), 32'd7);
        chk("s4_drop_valid", 32'(bus.BusValid), 32'd0);
        tick();
        chk("s4_data7", 32'(bus.BusData), 32'd7);
        chk("s4_valid7", 32'(bus.BusValid), 32'd1);

        // 5: wrap-around after source 6 releases picks source 0 first.
        bus.Req = 8'h40;
        tick();
        chk("s5_grant6", 32'(bus.Grant), 32'h40);
        chk("s5_sel6", 32'(bus.Sel), 32'd6);
        bus.Req = 8'h41;
        for (int j = 1; j <= 8; j++) begin
            tick();
            chk("s5_rotate", 32'(bus.Grant), (j < 4) ? 32'h40 : ((j < 8) ? 32'h01 : 32'h40));
        end

        // 6: reset in the middle of a grant to source 5.
        do_reset();
        bus.Req = 8'hFF;
        for (int k = 0; k <= 20; k++) begin
            tick();
        end
        chk("s6_grant5", 32'(bus.Grant), 32'h20);
        chk("s6_sel5", 32'(bus.Sel), 32'd5);
        rst = 1'b1;
        tick();
        chk("s6_rst_grant", 32'(bus.Grant), 32'h00);
        chk("s6_rst_sel", 32'(bus.Sel), 32'd0);
        chk("s6_rst_owner", 32'(bus.Owner), 32'd0);
        chk("s6_rst_data", 32'(bus.BusData), 32'd0);
        chk("s6_rst_valid", 32'(bus.BusValid), 32'd0);
        rst = 1'b0;
        tick();
        chk("s6_first_grant", 32'(bus.Grant), 32'h01);
        chk("s6_first_sel", 32'(bus.Sel), 32'd0);
        chk("s6_first_valid", 32'(bus.BusValid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
